uart_rx_frame: RTL and testbench
================================

UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of the Prescale input.
REQ-003 SHALL have port CLK  input  1  oversampling clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, LSB first.
REQ-006 SHALL have port Prescale  input  PRESCALE_W  oversampling ratio, legal values 8, 16 or 32.
REQ-007 SHALL have port PAR_EN  input  1  parity bit present.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port P_DATA  output  DATA_WIDTH  last good received word.
REQ-010 SHALL have port Data_Valid  output  1  one-cycle pulse when P_DATA updates.
REQ-011 SHALL have port Parity_Error  output  1  one-cycle pulse on a parity mismatch.
REQ-012 SHALL have port Stop_Error  output  1  one-cycle pulse when the stop bit samples 0.

Function
REQ-013 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP and CHECK.
REQ-014 SHALL latch Prescale, PAR_EN and PAR_TYP on the IDLE->START transition and hold them for the whole frame.
REQ-015 SHALL treat any illegal Prescale value as 8.
REQ-016 SHALL run an edge counter from 0 to Prescale-1 per bit period; it wraps to 0 at the bit boundary and the bit counter increments on the wrap.
REQ-017 SHALL leave IDLE for START in the cycle after RX_IN is sampled low, with the edge counter at 0.
REQ-018 SHALL take the bit decision once the edge counter passes the sample point defined in REQ-031/REQ-032.
REQ-019 SHALL return to IDLE from START if the start-bit decision is 1 (glitch); no output pulses in that case.
REQ-020 SHALL shift DATA_WIDTH decisions LSB-first into an internal shift register; P_DATA SHALL NOT change during reception.
REQ-021 SHALL enter PARITY after DATA only when the latched PAR_EN is 1, otherwise enter STOP.
REQ-022 SHALL, in PARITY, compare the decision with the XOR of the data bits (inverted when PAR_TYP=1) and record any mismatch.
REQ-023 SHALL, in STOP, record a stop error when the stop decision is 0.
REQ-024 SHALL enter CHECK at the stop-bit wrap and spend exactly one cycle there.
REQ-025 SHALL, in CHECK with no error: load P_DATA and pulse Data_Valid for 1 cycle.
REQ-026 SHALL, in CHECK with any error: leave P_DATA unchanged, pulse Data_Valid=0, and pulse the corresponding error output(s); both errors may pulse in the same cycle.
REQ-027 SHALL leave CHECK for START if RX_IN=0 in that cycle (back-to-back frames), otherwise for IDLE.
REQ-028 SHALL keep RX_IN changes outside the sample window without effect on the decision.

Reset
REQ-029 SHALL, when RST=0, immediately force: FSM=IDLE, counters=0, shift register=0, P_DATA=0, Data_Valid=0, Parity_Error=0, Stop_Error=0.
REQ-030 SHALL discard a frame interrupted by reset; after release it waits in IDLE for a new falling level on RX_IN.

Configuration
REQ-031 SHALL, with macro UART_RX_MAJORITY_SAMPLE_EN defined, sample at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1, take the majority of the three, and make the decision valid at Prescale/2+1.
REQ-032 SHALL, without UART_RX_MAJORITY_SAMPLE_EN, take a single sample at edge count Prescale/2 as the decision.

Structure
REQ-033 SHALL place the FSM state encodings and the legal prescale constants (8, 16, 32) in the shared package uart_pkg, reused by the TX side.
REQ-034 SHALL use one sub-module, uart_rx_sampler, holding the edge counter, bit counter and sample/majority logic; FSM, shift register and checks stay in uart_rx_frame.

Verification
REQ-035 SHALL cover: Prescale=8, PAR_EN=0, byte 0xA5, stop=1 -> P_DATA=0xA5, Data_Valid pulses 1 cycle, no error pulses.
REQ-036 SHALL cover: Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C with parity bit 1 -> Parity_Error pulse, Data_Valid=0, P_DATA keeps its previous value.
REQ-037 SHALL cover: Prescale=32, stop bit driven 0 on byte 0x81 -> Stop_Error pulse, P_DATA unchanged.
REQ-038 SHALL cover: RX_IN low for 2 cycles then high (Prescale=8) -> returns to IDLE, no output pulses.
REQ-039 SHALL cover: back-to-back frames 0x55 then 0xAA, no idle gap -> two Data_Valid pulses, P_DATA=0x55 then 0xAA.
REQ-040 SHALL cover: RST asserted mid-DATA of 0xFF -> all outputs 0 at once; next frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : UART state encodings and legal oversampling ratios (RX and TX).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_CHECK  = 3'd5
   } uart_state_e;

   localparam int unsigned c_PRESCALE_8  = 8;
   localparam int unsigned c_PRESCALE_16 = 16;
   localparam int unsigned c_PRESCALE_32 = 32;

   function automatic logic prescale_is_legal(input int unsigned p);
      return (p == c_PRESCALE_8) || (p == c_PRESCALE_16) || (p == c_PRESCALE_32);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
//------------------------------------------------------------------------------
// uart_rx_sampler : edge/bit counters and mid-bit decision for the UART RX.
// Majority-of-three sampling when UART_RX_MAJORITY_SAMPLE_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned PRESCALE_W = 6,
   parameter int unsigned BIT_W      = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  run_i,
   input  logic                  rx_i,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic [BIT_W-1:0]      bit_cnt_o,
   output logic                  wrap_o,
   output logic                  dec_o,
   output logic                  dec_vld_o
);

   logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
   logic [PRESCALE_W-1:0] w_half;

   assign w_half    = prescale_i >> 1;
   assign wrap_o    = run_i && (edge_cnt_q == (prescale_i - PRESCALE_W'(1)));
   assign bit_cnt_o = bit_cnt_q;

   // Counters sit at zero whenever the frame FSM is not inside a bit period.
   always_comb begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      bit_cnt_d  = bit_cnt_q;
      if (!run_i) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (wrap_o) begin
         edge_cnt_d = '0;
         bit_cnt_d  = bit_cnt_q + BIT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

`ifdef UART_RX_MAJORITY_SAMPLE_EN
   logic s0_q, s1_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s0_q <= 1'b1;
         s1_q <= 1'b1;
      end else begin
         if (run_i && (edge_cnt_q == (w_half - PRESCALE_W'(1)))) s0_q <= rx_i;
         if (run_i && (edge_cnt_q == w_half))                    s1_q <= rx_i;
      end
   end

   // Third sample is the live line value, so the vote resolves in that cycle.
   assign dec_vld_o = run_i && (edge_cnt_q == (w_half + PRESCALE_W'(1)));
   assign dec_o     = (s0_q & s1_q) | (s0_q & rx_i) | (s1_q & rx_i);
`else
   assign dec_vld_o = run_i && (edge_cnt_q == w_half);
   assign dec_o     = rx_i;
`endif

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
//------------------------------------------------------------------------------
// uart_rx_frame : UART receiver frame FSM, shift register, parity/stop checks.
// Optional majority sampling via UART_RX_MAJORITY_SAMPLE_EN (see sampler).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Parity_Error,
   output logic                  Stop_Error
);

   localparam int unsigned c_BIT_W = $clog2(DATA_WIDTH + 3);

   uart_state_e           state_q;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic                  par_en_q, par_typ_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic                  perr_q, serr_q;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic                  data_valid_q, parity_error_q, stop_error_q;

   logic                  w_run, w_start, w_wrap, w_dec, w_dec_vld, w_par_exp;
   logic [c_BIT_W-1:0]    w_bit_cnt;

   assign prescale_d = prescale_is_legal(32'(Prescale)) ? Prescale
                                                        : PRESCALE_W'(c_PRESCALE_8);
   assign w_run      = (state_q != ST_IDLE) && (state_q != ST_CHECK);
   assign w_start    = !RX_IN && ((state_q == ST_IDLE) || (state_q == ST_CHECK));
   assign w_par_exp  = (^shreg_q) ^ par_typ_q;

   uart_rx_sampler #(
      .PRESCALE_W (PRESCALE_W),
      .BIT_W      (c_BIT_W)
   ) u_sampler (
      .CLK        (CLK),
      .RST        (RST),
      .run_i      (w_run),
      .rx_i       (RX_IN),
      .prescale_i (prescale_q),
      .bit_cnt_o  (w_bit_cnt),
      .wrap_o     (w_wrap),
      .dec_o      (w_dec),
      .dec_vld_o  (w_dec_vld)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q        <= ST_IDLE;
         prescale_q     <= PRESCALE_W'(c_PRESCALE_8);
         par_en_q       <= 1'b0;
         par_typ_q      <= 1'b0;
         shreg_q        <= '0;
         perr_q         <= 1'b0;
         serr_q         <= 1'b0;
         p_data_q       <= '0;
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         stop_error_q   <= 1'b0;
      end else begin
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         stop_error_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
               if (w_dec_vld && w_dec) state_q <= ST_IDLE;
               else if (w_wrap)        state_q <= ST_DATA;
            end
            ST_DATA: begin
               if (w_dec_vld) shreg_q <= {w_dec, shreg_q[DATA_WIDTH-1:1]};
               if (w_wrap && (w_bit_cnt == c_BIT_W'(DATA_WIDTH)))
                  state_q <= par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
               if (w_dec_vld) perr_q <= (w_dec != w_par_exp);
               if (w_wrap)    state_q <= ST_STOP;
            end
            ST_STOP: begin
               if (w_dec_vld) serr_q <= !w_dec;
               if (w_wrap)    state_q <= ST_CHECK;
            end
            ST_CHECK: begin
               if (!perr_q && !serr_q) begin
                  p_data_q     <= shreg_q;
                  data_valid_q <= 1'b1;
               end
               parity_error_q <= perr_q;
               stop_error_q   <= serr_q;
               state_q        <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
         // A low line in IDLE or CHECK opens a frame; overrides the case above.
         if (w_start) begin
            state_q    <= ST_START;
            prescale_q <= prescale_d;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
         end
      end
   end

   assign P_DATA       = p_data_q;
   assign Data_Valid   = data_valid_q;
   assign Parity_Error = parity_error_q;
   assign Stop_Error   = stop_error_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
//------------------------------------------------------------------------------
// tb_uart_rx_frame : randomized scoreboard bench for uart_rx_frame.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_frame;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 6;

   logic          CLK      = 1'b0;
   logic          RST      = 1'b1;
   logic          RX_IN    = 1'b1;
   logic [PW-1:0] Prescale = PW'(8);
   logic          PAR_EN   = 1'b0;
   logic          PAR_TYP  = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid, Parity_Error, Stop_Error;

   typedef struct packed {
      logic          dv;
      logic          pe;
      logic          se;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_q[$];
   int            checks    = 0;
   int            failures  = 0;
   logic [DW-1:0] last_good = '0;
   int unsigned   slip      = 0;

   uart_rx_frame #(
      .DATA_WIDTH (DW),
      .PRESCALE_W (PW)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .Prescale     (Prescale),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .P_DATA       (P_DATA),
      .Data_Valid   (Data_Valid),
      .Parity_Error (Parity_Error),
      .Stop_Error   (Stop_Error)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic int unsigned eff_pre(input int unsigned p);
      return (p == 8 || p == 16 || p == 32) ? p : 8;
   endfunction

   // Reference outcome of one frame from the line-level contents.
   function automatic exp_t model(input bit pen, input bit ptyp, input logic [DW-1:0] d,
                                  input bit pbit, input bit stopb);
      exp_t e;
      bit   odd_ones;
      odd_ones = ($countones(d) % 2) == 1;
      e.pe   = pen && (pbit != (odd_ones ^ ptyp));
      e.se   = !stopb;
      e.dv   = !e.pe && !e.se;
      e.data = d;
      return e;
   endfunction

   function automatic int unsigned pick_pre();
      case ($urandom_range(0, 7))
         0, 1:    return 8;
         2, 3:    return 16;
         4, 5:    return 32;
         6:       return 12;
         default: return $urandom_range(0, 63);
      endcase
   endfunction

   task automatic drive_bit(input logic b, input int unsigned p);
      RX_IN = b;
      repeat (p) @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input int unsigned pre, input bit pen, input bit ptyp,
                             input logic [DW-1:0] d, input bit pbit, input bit stopb,
                             input int unsigned gap);
      int unsigned p;
      p        = eff_pre(pre);
      Prescale = PW'(pre);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      drive_bit(1'b0, p);
      for (int i = 0; i < int'(DW); i++) drive_bit(d[i], p);
      if (pen) drive_bit(pbit, p);
      drive_bit(stopb, p);
      exp_q.push_back(model(pen, ptyp, d, pbit, stopb));
      RX_IN = 1'b1;
      repeat (gap) @(posedge CLK);
      #1;
      // A zero-gap start is only seen one cycle late by the receiver.
      slip = (gap >= slip + 1) ? 0 : slip + 1 - gap;
   endtask

   task automatic send_glitch(input int unsigned pre, input int unsigned len);
      int unsigned p;
      p        = eff_pre(pre);
      Prescale = PW'(pre);
      RX_IN    = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      RX_IN = 1'b0;
      repeat (len) @(posedge CLK);
      #1;
      RX_IN = 1'b1;
      repeat (p + 4) @(posedge CLK);
      #1;
      slip = 0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST) last_good = '0;
         if (Data_Valid || Parity_Error || Stop_Error) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", 32'({Data_Valid, Parity_Error, Stop_Error}), 32'(0));
            end else begin
               e = exp_q.pop_front();
               chk("data_valid",   32'(Data_Valid),   32'(e.dv));
               chk("parity_error", 32'(Parity_Error), 32'(e.pe));
               chk("stop_error",   32'(Stop_Error),   32'(e.se));
               if (e.dv) last_good = e.data;
               chk("p_data_on_pulse", 32'(P_DATA), 32'(last_good));
            end
         end else begin
            chk("p_data_hold", 32'(P_DATA), 32'(last_good));
         end
      end
   endtask

   initial begin
      int unsigned pre, g;
      bit          pen, ptyp, pbit, stopb;
      logic [DW-1:0] d;

      fork
         monitor();
      join_none

      #1 RST = 1'b0;
      #1;
      chk("rst_p_data",       32'(P_DATA),       32'(0));
      chk("rst_data_valid",   32'(Data_Valid),   32'(0));
      chk("rst_parity_error", 32'(Parity_Error), 32'(0));
      chk("rst_stop_error",   32'(Stop_Error),   32'(0));
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;

      send_frame(8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3);
      send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 3);
      send_frame(32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 4);
      send_glitch(8, 2);
      send_frame(8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0);
      send_frame(8,  1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 3);

      // Reset in the middle of the data bits of an 0xFF frame.
      Prescale = PW'(8);
      PAR_EN   = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      drive_bit(1'b0, 8);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 8);
      repeat (3) @(posedge CLK);
      #3 RST = 1'b0;
      #1;
      chk("midrst_p_data",       32'(P_DATA),       32'(0));
      chk("midrst_data_valid",   32'(Data_Valid),   32'(0));
      chk("midrst_parity_error", 32'(Parity_Error), 32'(0));
      chk("midrst_stop_error",   32'(Stop_Error),   32'(0));
      RX_IN = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      slip = 0;
      repeat (2) @(posedge CLK);
      #1;
      send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 3);

      for (int n = 0; n < 40; n++) begin
         pre = pick_pre();
         if ($urandom_range(0, 9) == 0) begin
            send_glitch(pre, $urandom_range(1, eff_pre(pre) / 4));
         end else begin
            pen   = 1'($urandom_range(0, 1));
            ptyp  = 1'($urandom_range(0, 1));
            d     = DW'($urandom_range(0, 255));
            pbit  = 1'($urandom_range(0, 1));
            stopb = $urandom_range(0, 4) != 0;
            g     = $urandom_range(0, 3);
            if (slip != 0 && g == 0) g = 2;
            send_frame(pre, pen, ptyp, d, pbit, stopb, g);
         end
      end

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge CLK);
      chk("drain_queue_empty", 32'(exp_q.size()), 32'(0));
      repeat (5) @(posedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
